pipeline_ctrl: RTL

Central stall/flush controller for the 5-stage MIPS core. It collects stall requests from IF, ID, EX and MEM and the exception type resolved in MEM, and drives the shared `stall[5:0]`/`flush` bus that sequences every pipeline latch (pc_reg, if_id, id_ex, ex_mem, mem_wb). It also supplies the redirect PC on exceptions and keeps stall statistics plus a stall watchdog for debug.

---
 rtl/pipeline_ctrl_if.sv | 43 ++++
 rtl/pipeline_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush bus between the pipeline controller and the pipeline.
// master: controller side (drives stall/flush/redirect); slave: pipeline side.
interface pipeline_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  modport master (
    input  stallreq_from_if,
    input  stallreq_from_id,
    input  stallreq_from_ex,
    input  stallreq_from_mem,
    input  excepttype,
    input  cp0_epc,
    output stall,
    output flush,
    output new_pc,
    output stall_cycles,
    output stall_timeout
  );

  modport slave (
    output stallreq_from_if,
    output stallreq_from_id,
    output stallreq_from_ex,
    output stallreq_from_mem,
    output excepttype,
    output cp0_epc,
    input  stall,
    input  flush,
    input  new_pc,
    input  stall_cycles,
    input  stall_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: stall[5:0]/flush/new_pc (comb),
// stall_cycles counter and sticky stall watchdog. clk, rst (async, low).
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 1024
) (
  input logic             clk,
  input logic             rst,
  pipeline_ctrl_if.master bus
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] FLUSH   = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_C = CW'(STALL_TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic [31:0]   sc_q, sc_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          to_q, to_d;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mask;
  logic        exc_ok;

  // id/ex requests after a flush come from squashed bubbles
  assign mask   = (state_q != RUN);
  assign exc_ok = (state_q != FLUSH) && (|bus.excepttype);

  always_comb begin
    state_d = state_q;
    stall   = 6'b000000;
    flush   = 1'b0;
    new_pc  = 32'h0;
    if (exc_ok) begin
      flush   = 1'b1;
      new_pc  = (bus.excepttype == 32'h0000_000e) ?
                bus.cp0_epc : EXC_VECTOR;
      state_d = FLUSH;
    end else begin
      if (bus.stallreq_from_mem)
        stall = 6'b011111;
      else if (bus.stallreq_from_ex && !mask)
        stall = 6'b001111;
      else if (bus.stallreq_from_id && !mask)
        stall = 6'b000111;
      else if (bus.stallreq_from_if)
        stall = 6'b000011;
      unique case (state_q)
        RUN:     state_d = RUN;
        FLUSH:   state_d = RECOVER;
        RECOVER: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    sc_d = sc_q;
    if (stall[0] && (sc_q != 32'hFFFF_FFFF))
      sc_d = sc_q + 32'd1;
  end

  always_comb begin
    wd_d = wd_q;
    if (!stall[0] || flush)
      wd_d = '0;
    else if (wd_q != TO_C)
      wd_d = wd_q + 1'b1;
    to_d = to_q | (wd_d == TO_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      sc_q    <= 32'h0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  assign bus.stall         = stall;
  assign bus.flush         = flush;
  assign bus.new_pc        = new_pc;
  assign bus.stall_cycles  = sc_q;
  assign bus.stall_timeout = to_q;

endmodule
